// File: rtl/hash_job_sequencer.sv
// hash_job_sequencer
//   Runs one SHA-3/SHAKE hash core job end to end by driving the 20-bit
//   args command word through load, absorb, finalize and squeeze. It counts
//   input words (wen) and output words (dout_req), so the core's stream
//   front ends can move data without software timing the phases.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   job_valid       job request; accepted only while job_ready=1
//   job_ready       combinational: sequencer is in IDLE
//   job_mode        0=SHA3_256 1=SHA3_512 2=SHAKE_128 3=SHAKE_256
//                   4=SHA3_224 5=SHA3_384
//   job_mask        masked implementation select
//   job_in_words    32-bit words to absorb
//   job_out_words   32-bit words to squeeze (0 = mode default length)
//   args            registered command word to the core
//   src_rst         one-cycle pulse on the first LOAD cycle
//   wen, dout_req   core input/output word strobes (observed only)
//   core_done       core finalize-complete indication
//   busy            job in progress (any state but IDLE)
//   job_done        one-cycle pulse when a job completes
//   job_err         one-cycle pulse on a rejected or aborted job
//   ovf             sticky: stray wen/dout_req/core_done outside its phase

module hash_job_sequencer #(
    parameter int unsigned LOAD_CYC = 4,
    parameter int unsigned GAP_CYC  = 2,
    parameter int unsigned TIMEOUT  = 4096,
    parameter int unsigned CW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          job_valid,
    output logic          job_ready,
    input  logic [2:0]    job_mode,
    input  logic          job_mask,
    input  logic [CW-1:0] job_in_words,
    input  logic [CW-1:0] job_out_words,
    output logic [19:0]   args,
    output logic          src_rst,
    input  logic          wen,
    input  logic          dout_req,
    input  logic          core_done,
    output logic          busy,
    output logic          job_done,
    output logic          job_err,
    output logic          ovf
);

    localparam int unsigned PH_MAX = (LOAD_CYC > GAP_CYC) ? LOAD_CYC : GAP_CYC;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ABSORB,
        S_GAP1,
        S_FINAL,
        S_GAP2,
        S_SQUEEZE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    mode_q, mode_d;
    logic          mask_q, mask_d;
    logic [CW-1:0] in_words_q, in_words_d;
    logic [CW-1:0] out_words_q, out_words_d;
    logic [CW-1:0] in_cnt_q, in_cnt_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [19:0]   args_q, args_d;
    logic          src_rst_q, src_rst_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;

    logic          reject;
    logic          watched;
    logic [CW:0]   in_next;
    logic [CW:0]   out_next;

    function automatic logic [CW-1:0] default_out(input logic [2:0] m);
        case (m)
            3'd0:    return CW'(8);
            3'd1:    return CW'(16);
            3'd4:    return CW'(7);
            3'd5:    return CW'(12);
            default: return '0;
        endcase
    endfunction

    function automatic logic [19:0] args_for(input state_t s, input logic [2:0] m,
                                             input logic k);
        logic [19:0] a;
        a      = '0;
        a[2:0] = m;
        a[3]   = k;
        case (s)
            S_IDLE:    a = '0;
            S_LOAD:    a[15] = 1'b1;
            S_ABSORB:  begin a[18] = 1'b1; a[9] = 1'b1; end
            S_FINAL:   a[17] = 1'b1;
            S_SQUEEZE: a[16] = 1'b1;
            default:   ;
        endcase
        return a;
    endfunction

    assign reject = (job_mode > 3'd5) ||
                    (((job_mode == 3'd2) || (job_mode == 3'd3)) && (job_out_words == '0));
    assign watched  = (state_q == S_ABSORB) || (state_q == S_FINAL) || (state_q == S_SQUEEZE);
    assign in_next  = {1'b0, in_cnt_q} + (CW+1)'(1);
    assign out_next = {1'b0, out_cnt_q} + (CW+1)'(1);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        mask_d      = mask_q;
        in_words_d  = in_words_q;
        out_words_d = out_words_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        ph_d        = ph_q;
        wd_d        = wd_q;
        ovf_d       = ovf_q;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    ovf_d       = 1'b0;
                    mode_d      = job_mode;
                    mask_d      = job_mask;
                    in_words_d  = job_in_words;
                    out_words_d = (job_out_words != '0) ? job_out_words : default_out(job_mode);
                    in_cnt_d    = '0;
                    out_cnt_d   = '0;
                    ph_d        = '0;
                    if (reject) err_d = 1'b1;
                    else        state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (ph_q == PH_W'(LOAD_CYC - 1)) begin
                    ph_d    = '0;
                    state_d = (in_words_q == '0) ? S_GAP1 : S_ABSORB;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_ABSORB: begin
                if (wen) begin
                    if (in_cnt_q != '1) in_cnt_d = in_cnt_q + 1'b1;
                    if (in_next >= {1'b0, in_words_q}) state_d = S_GAP1;
                end
            end
            S_GAP1, S_GAP2: begin
                if (ph_q == PH_W'(GAP_CYC - 1)) begin
                    ph_d    = '0;
                    state_d = (state_q == S_GAP1) ? S_FINAL : S_SQUEEZE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_FINAL: begin
                if (core_done) state_d = S_GAP2;
            end
            S_SQUEEZE: begin
                if (dout_req) begin
                    if (out_cnt_q != '1) out_cnt_d = out_cnt_q + 1'b1;
                    if (out_next >= {1'b0, out_words_q}) state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Strobes outside their own phase are dropped and flagged.
        if (wen && (state_q != S_ABSORB))       ovf_d = 1'b1;
        if (dout_req && (state_q != S_SQUEEZE)) ovf_d = 1'b1;
        if (core_done && (state_q != S_FINAL))  ovf_d = 1'b1;

        // Stall watchdog: any strobe or phase change restarts it; expiry aborts.
        if (!watched || wen || dout_req || (state_d != state_q)) begin
            wd_d = '0;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
            wd_d    = '0;
            err_d   = 1'b1;
            state_d = S_IDLE;
        end else begin
            wd_d = wd_q + 1'b1;
        end

        // Outputs are registered from the next state so they line up with it.
        args_d    = args_for(state_d, mode_d, mask_d);
        src_rst_d = (state_d == S_LOAD) && (state_q != S_LOAD);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            mask_q      <= 1'b0;
            in_words_q  <= '0;
            out_words_q <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            ph_q        <= '0;
            wd_q        <= '0;
            args_q      <= '0;
            src_rst_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            mask_q      <= mask_d;
            in_words_q  <= in_words_d;
            out_words_q <= out_words_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            ph_q        <= ph_d;
            wd_q        <= wd_d;
            args_q      <= args_d;
            src_rst_q   <= src_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
        end
    end

    assign job_ready = (state_q == S_IDLE);
    assign args      = args_q;
    assign src_rst   = src_rst_q;
    assign busy      = busy_q;
    assign job_done  = done_q;
    assign job_err   = err_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_hash_job_sequencer.sv
// tb_hash_job_sequencer
//   Bench for hash_job_sequencer. Each job pushes its expected args segments
//   (value, cycle count) into a queue; a monitor records observed non-zero
//   args segments, and each test pops both and compares them.

module tb_hash_job_sequencer;

    localparam int unsigned LOAD_CYC = 4;
    localparam int unsigned GAP_CYC  = 2;
    localparam int unsigned TIMEOUT  = 16;
    localparam int unsigned CW       = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          job_valid;
    logic          job_ready;
    logic [2:0]    job_mode;
    logic          job_mask;
    logic [CW-1:0] job_in_words;
    logic [CW-1:0] job_out_words;
    logic [19:0]   args;
    logic          src_rst;
    logic          wen;
    logic          dout_req;
    logic          core_done;
    logic          busy;
    logic          job_done;
    logic          job_err;
    logic          ovf;

    always #5 clk = ~clk;

    hash_job_sequencer #(
        .LOAD_CYC(LOAD_CYC),
        .GAP_CYC (GAP_CYC),
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_mode     (job_mode),
        .job_mask     (job_mask),
        .job_in_words (job_in_words),
        .job_out_words(job_out_words),
        .args         (args),
        .src_rst      (src_rst),
        .wen          (wen),
        .dout_req     (dout_req),
        .core_done    (core_done),
        .busy         (busy),
        .job_done     (job_done),
        .job_err      (job_err),
        .ovf          (ovf)
    );

    typedef struct {
        logic [19:0] val;
        int unsigned len;
    } seg_t;

    seg_t exp_q[$];
    seg_t obs_q[$];
    int   checks = 0;
    int   failures = 0;
    int   src_rst_cnt = 0;
    int   done_cnt = 0;
    logic [19:0] prev_args = '0;

    // Monitor samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        seg_t s;
        #1;
        if (!rst) begin
            if (src_rst)  src_rst_cnt++;
            if (job_done) done_cnt++;
            if (args != 20'h0) begin
                if ((args == prev_args) && (obs_q.size() > 0)) begin
                    s = obs_q.pop_back();
                    s.len++;
                    obs_q.push_back(s);
                end else begin
                    s.val = args;
                    s.len = 1;
                    obs_q.push_back(s);
                end
            end
            prev_args = args;
        end
    end

    task automatic push_seg(input logic [19:0] v, input int unsigned n);
        seg_t s;
        s.val = v;
        s.len = n;
        exp_q.push_back(s);
    endtask

    // Expected args trace: FINAL lasts 3 cycles because run_job raises
    // core_done two cycles after FINAL is first seen.
    task automatic push_exp(input logic [2:0] m, input logic k, input logic [15:0] iw,
                            input int unsigned nout);
        logic [19:0] base;
        base = {16'h0, k, m};
        push_seg(base | 20'h08000, LOAD_CYC);
        if (iw != 16'h0) push_seg(base | 20'h40200, iw);
        push_seg(base, GAP_CYC);
        push_seg(base | 20'h20000, 3);
        push_seg(base, GAP_CYC);
        push_seg(base | 20'h10000, nout);
        push_seg(base, 1);
    endtask

    task automatic run_job(input logic [2:0] m, input logic k, input logic [15:0] iw,
                           input logic [15:0] ow, input int unsigned nout, output bit to);
        int n;
        to = 1'b0;
        exp_q.delete();
        obs_q.delete();
        push_exp(m, k, iw, nout);
        @(negedge clk);
        job_valid = 1'b1; job_mode = m; job_mask = k;
        job_in_words = iw; job_out_words = ow;
        @(negedge clk);
        job_valid = 1'b0;
        if (iw != 16'h0) begin
            n = 0;
            while (!args[18] && n < 100) begin @(negedge clk); n++; end
            if (!args[18]) to = 1'b1;
            repeat (int'(iw)) begin wen = 1'b1; @(negedge clk); end
            wen = 1'b0;
        end
        n = 0;
        while (!args[17] && n < 100) begin @(negedge clk); n++; end
        if (!args[17]) to = 1'b1;
        repeat (2) @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        n = 0;
        while (!args[16] && n < 100) begin @(negedge clk); n++; end
        if (!args[16]) to = 1'b1;
        repeat (nout) begin dout_req = 1'b1; @(negedge clk); end
        dout_req = 1'b0;
        n = 0;
        while (!job_ready && n < 100) begin @(negedge clk); n++; end
        if (!job_ready) to = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        job_valid = 1'b0; job_mode = '0; job_mask = 1'b0;
        job_in_words = '0; job_out_words = '0;
        wen = 1'b0; dout_req = 1'b0; core_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (args !== 20'h0) begin failures++; $display("FAIL reset_args: got %05h want 00000", args); end
        checks++; if (job_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", job_ready); end
        checks++; if ({busy, job_done, job_err, ovf, src_rst} !== 5'b0) begin
            failures++; $display("FAIL reset_flags: got %b want 00000", {busy, job_done, job_err, ovf, src_rst});
        end
    endtask

    task automatic test_basic();
        bit to; seg_t e, o;
        done_cnt = 0;
        run_job(3'd1, 1'b0, 16'd4, 16'd0, 16, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL basic_timeout: got %b want 0", to); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front(); else begin o.val = 20'hFFFFF; o.len = 0; end
            checks++;
            if (o.val !== e.val || o.len != e.len) begin
                failures++; $display("FAIL basic_seg: got %05h x%0d want %05h x%0d", o.val, o.len, e.val, e.len);
            end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL basic_extra: got %0d extra segs want 0", obs_q.size()); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done: got %0d want 1", done_cnt); end
        checks++; if (args !== 20'h0 || job_ready !== 1'b1) begin
            failures++; $display("FAIL basic_idle: got args=%05h ready=%b want 00000/1", args, job_ready);
        end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL basic_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_masked();
        bit to; seg_t e, o;
        src_rst_cnt = 0;
        run_job(3'd1, 1'b1, 16'd2, 16'd0, 16, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL masked_timeout: got %b want 0", to); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front(); else begin o.val = 20'hFFFFF; o.len = 0; end
            checks++;
            if (o.val !== e.val || o.len != e.len) begin
                failures++; $display("FAIL masked_seg: got %05h x%0d want %05h x%0d", o.val, o.len, e.val, e.len);
            end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL masked_extra: got %0d extra segs want 0", obs_q.size()); end
        checks++; if (src_rst_cnt != 1) begin failures++; $display("FAIL masked_src_rst: got %0d want 1", src_rst_cnt); end
    endtask

    task automatic test_reject();
        logic [2:0]  modes [2];
        logic [15:0] outs  [2];
        modes[0] = 3'd6; outs[0] = 16'd4;
        modes[1] = 3'd3; outs[1] = 16'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            job_valid = 1'b1; job_mode = modes[i]; job_mask = 1'b0;
            job_in_words = 16'd1; job_out_words = outs[i];
            @(negedge clk);
            job_valid = 1'b0;
            checks++; if (job_err !== 1'b1) begin failures++; $display("FAIL reject_err%0d: got %b want 1", i, job_err); end
            checks++; if (args !== 20'h0 || busy !== 1'b0 || job_ready !== 1'b1) begin
                failures++; $display("FAIL reject_idle%0d: got args=%05h busy=%b ready=%b want 00000/0/1", i, args, busy, job_ready);
            end
            @(negedge clk);
            checks++; if (job_err !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL reject_pulse%0d: got err=%b busy=%b want 0/0", i, job_err, busy);
            end
        end
    endtask

    task automatic test_no_absorb();
        bit to; seg_t e, o;
        done_cnt = 0;
        run_job(3'd2, 1'b0, 16'd0, 16'd5, 5, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL noabs_timeout: got %b want 0", to); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front(); else begin o.val = 20'hFFFFF; o.len = 0; end
            checks++;
            if (o.val !== e.val || o.len != e.len) begin
                failures++; $display("FAIL noabs_seg: got %05h x%0d want %05h x%0d", o.val, o.len, e.val, e.len);
            end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL noabs_extra: got %0d extra segs want 0", obs_q.size()); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL noabs_done: got %0d want 1", done_cnt); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL noabs_ovf_pre: got %b want 0", ovf); end
        dout_req = 1'b1;
        @(negedge clk);
        dout_req = 1'b0;
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL noabs_ovf_stray: got %b want 1", ovf); end
    endtask

    task automatic test_timeout();
        bit to; seg_t e, o; int n; int k;
        @(negedge clk);
        job_valid = 1'b1; job_mode = 3'd0; job_mask = 1'b0;
        job_in_words = 16'd8; job_out_words = 16'd0;
        @(negedge clk);
        job_valid = 1'b0;
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL tmo_ovf_clear: got %b want 0", ovf); end
        n = 0;
        while (!args[18] && n < 100) begin @(negedge clk); n++; end
        checks++; if (args[18] !== 1'b1) begin failures++; $display("FAIL tmo_absorb: got args=%05h want absorb", args); end
        repeat (3) begin wen = 1'b1; @(negedge clk); end
        wen = 1'b0;
        k = 0;
        while (!job_err && k < 40) begin @(negedge clk); k++; end
        checks++; if (k != int'(TIMEOUT)) begin failures++; $display("FAIL tmo_cycles: got %0d want %0d", k, TIMEOUT); end
        checks++; if (args !== 20'h0 || job_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL tmo_idle: got args=%05h ready=%b busy=%b want 00000/1/0", args, job_ready, busy);
        end
        wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL tmo_ovf_stray: got %b want 1", ovf); end
        run_job(3'd4, 1'b1, 16'd1, 16'd0, 7, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL tmo_next_timeout: got %b want 0", to); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front(); else begin o.val = 20'hFFFFF; o.len = 0; end
            checks++;
            if (o.val !== e.val || o.len != e.len) begin
                failures++; $display("FAIL tmo_next_seg: got %05h x%0d want %05h x%0d", o.val, o.len, e.val, e.len);
            end
        end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL tmo_next_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_reset_mid_job();
        bit to; seg_t e, o; int n;
        done_cnt = 0;
        @(negedge clk);
        job_valid = 1'b1; job_mode = 3'd1; job_mask = 1'b0;
        job_in_words = 16'd1; job_out_words = 16'd0;
        @(negedge clk);
        job_valid = 1'b0;
        n = 0;
        while (!args[18] && n < 100) begin @(negedge clk); n++; end
        wen = 1'b1; @(negedge clk); wen = 1'b0;
        n = 0;
        while (!args[17] && n < 100) begin @(negedge clk); n++; end
        core_done = 1'b1; @(negedge clk); core_done = 1'b0;
        n = 0;
        while (!args[16] && n < 100) begin @(negedge clk); n++; end
        checks++; if (args !== 20'h10001) begin failures++; $display("FAIL rstmid_squeeze: got %05h want 10001", args); end
        repeat (3) begin dout_req = 1'b1; @(negedge clk); end
        dout_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (args !== 20'h0 || busy !== 1'b0) begin
            failures++; $display("FAIL rstmid_async: got args=%05h busy=%b want 00000/0", args, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (done_cnt != 0 || job_ready !== 1'b1 || job_err !== 1'b0) begin
            failures++; $display("FAIL rstmid_quiet: got done=%0d ready=%b err=%b want 0/1/0", done_cnt, job_ready, job_err);
        end
        run_job(3'd5, 1'b0, 16'd2, 16'd3, 3, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL rstmid_next_timeout: got %b want 0", to); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front(); else begin o.val = 20'hFFFFF; o.len = 0; end
            checks++;
            if (o.val !== e.val || o.len != e.len) begin
                failures++; $display("FAIL rstmid_next_seg: got %05h x%0d want %05h x%0d", o.val, o.len, e.val, e.len);
            end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL rstmid_next_done: got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_masked();
        test_reject();
        test_no_absorb();
        test_timeout();
        test_reset_mid_job();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
